// File: rtl/vga_mode_ctrl.sv
// Push-button display mode selector: synchronize and debounce the button, step the
// requested mode on each accepted press, and apply it to the datapath only at frame end.
module vga_mode_ctrl #(
  parameter int DB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button,
  input  logic       frame_end,
  output logic [1:0] S,
  output logic [1:0] req_mode,
  output logic       pending,
  output logic       mode_changed
);

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {STABLE_HI, WAIT_LO, STABLE_LO, WAIT_HI} db_state_t;

  db_state_t       state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            sync1, btn_s;
  logic            press;

  // Flops reset to 1 (released) so a button held through reset looks like a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      btn_s <= 1'b1;
    end else begin
      sync1 <= button;
      btn_s <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STABLE_HI;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    press    = 1'b0;
    case (state)
      STABLE_HI: if (!btn_s) begin
        state_nx = WAIT_LO;
        cnt_nx   = CW'(1);
      end
      WAIT_LO: begin
        if (btn_s) begin
          state_nx = STABLE_HI;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = STABLE_LO;
          cnt_nx   = '0;
          press    = 1'b1;
        end else begin
          cnt_nx   = cnt + CW'(1);
        end
      end
      STABLE_LO: if (btn_s) begin
        state_nx = WAIT_HI;
        cnt_nx   = CW'(1);
      end
      WAIT_HI: begin
        if (!btn_s) begin
          state_nx = STABLE_LO;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = STABLE_HI;
          cnt_nx   = '0;
        end else begin
          cnt_nx   = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = STABLE_HI;
        cnt_nx   = '0;
      end
    endcase
  end

  // Mode cycle order 00 -> 10 -> 01 -> 11 -> 00.
  function automatic logic [1:0] next_mode(input logic [1:0] m);
    case (m)
      2'b00:   next_mode = 2'b10;
      2'b10:   next_mode = 2'b01;
      2'b01:   next_mode = 2'b11;
      default: next_mode = 2'b00;
    endcase
  endfunction

  assign pending = (req_mode != S);

  // S samples the pre-press req_mode when a press and frame_end share an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      S            <= 2'b00;
      req_mode     <= 2'b00;
      mode_changed <= 1'b0;
    end else begin
      mode_changed <= frame_end && pending;
      if (frame_end && pending) S <= req_mode;
      if (press) req_mode <= next_mode(req_mode);
    end
  end

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Directed bench for vga_mode_ctrl with DB_CYCLES=4: per-step vector table plus
// hand-written latency and pulse-width sequences.
module tb_vga_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       button = 1'b1;
  logic       frame_end = 1'b0;
  logic [1:0] S, req_mode;
  logic       pending, mode_changed;

  int errors = 0;
  int checks = 0;

  vga_mode_ctrl #(.DB_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .button(button), .frame_end(frame_end),
    .S(S), .req_mode(req_mode), .pending(pending), .mode_changed(mode_changed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, btn, fe;
    int         n;
    logic [1:0] req, s;
    logic       pend, mc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic b, input logic f, input int n,
                     input logic [1:0] rq, input logic [1:0] s, input logic p, input logic mc);
    vec_t v;
    v.rst = r; v.btn = b; v.fe = f; v.n = n;
    v.req = rq; v.s = s; v.pend = p; v.mc = mc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] prev, m;
    logic [1:0] seq [4];
    int lat, mc_cnt;
    seq[0] = 2'b10; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b00;

    // reset state
    add(1,1,0,2,  2'b00,2'b00,0,0);
    add(0,1,0,3,  2'b00,2'b00,0,0);
    // clean press, long hold, apply at frame end, idle frame end, release
    add(0,0,0,5,  2'b00,2'b00,0,0);
    add(0,0,0,1,  2'b10,2'b00,1,0);
    add(0,0,0,20, 2'b10,2'b00,1,0);
    add(0,0,1,1,  2'b10,2'b10,0,1);
    add(0,0,0,1,  2'b10,2'b10,0,0);
    add(0,0,1,1,  2'b10,2'b10,0,0);
    add(0,1,0,6,  2'b10,2'b10,0,0);
    // bounce: 2-cycle low/high for 12 cycles, then hold low
    add(1,1,0,1,  2'b00,2'b00,0,0);
    add(0,1,0,2,  2'b00,2'b00,0,0);
    for (int i = 0; i < 6; i++) add(0, (i % 2 == 1), 0, 2, 2'b00,2'b00,0,0);
    add(0,0,0,5,  2'b00,2'b00,0,0);
    add(0,0,0,1,  2'b10,2'b00,1,0);
    add(0,0,0,30, 2'b10,2'b00,1,0);
    add(0,1,0,6,  2'b10,2'b00,1,0);
    // three presses inside one frame, then a single jump of S
    add(1,1,0,1,  2'b00,2'b00,0,0);
    add(0,1,0,2,  2'b00,2'b00,0,0);
    add(0,0,0,6,  2'b10,2'b00,1,0);
    add(0,1,0,6,  2'b10,2'b00,1,0);
    add(0,0,0,6,  2'b01,2'b00,1,0);
    add(0,1,0,6,  2'b01,2'b00,1,0);
    add(0,0,0,6,  2'b11,2'b00,1,0);
    add(0,1,0,6,  2'b11,2'b00,1,0);
    add(0,1,1,1,  2'b11,2'b11,0,1);
    add(0,1,0,1,  2'b11,2'b11,0,0);
    // press accepted on the frame_end edge
    add(1,1,0,1,  2'b00,2'b00,0,0);
    add(0,1,0,2,  2'b00,2'b00,0,0);
    add(0,0,0,6,  2'b10,2'b00,1,0);
    add(0,1,0,6,  2'b10,2'b00,1,0);
    add(0,0,0,5,  2'b10,2'b00,1,0);
    add(0,0,1,1,  2'b01,2'b10,1,1);
    add(0,0,0,1,  2'b01,2'b10,1,0);
    // reset in WAIT_LO with cnt=2 and a change pending
    add(0,1,0,6,  2'b01,2'b10,1,0);
    add(0,0,0,4,  2'b01,2'b10,1,0);
    add(1,1,0,1,  2'b00,2'b00,0,0);
    add(0,1,0,10, 2'b00,2'b00,0,0);
    // full wrap, each press applied
    prev = 2'b00;
    for (int i = 0; i < 4; i++) begin
      m = seq[i];
      add(0,0,0,6, m,prev,1,0);
      add(0,1,0,6, m,prev,1,0);
      add(0,1,1,1, m,m,0,1);
      add(0,1,0,1, m,m,0,0);
      prev = m;
    end
    // button held low through reset release
    add(1,0,0,2,  2'b00,2'b00,0,0);
    add(0,0,0,5,  2'b00,2'b00,0,0);
    add(0,0,0,1,  2'b10,2'b00,1,0);

    #2;
    foreach (vecs[i]) begin
      rst = vecs[i].rst; button = vecs[i].btn; frame_end = vecs[i].fe;
      repeat (vecs[i].n) tick();
      chk($sformatf("v%0d req_mode", i), req_mode, vecs[i].req);
      chk($sformatf("v%0d S", i), S, vecs[i].s);
      chk($sformatf("v%0d pending", i), {1'b0, pending}, {1'b0, vecs[i].pend});
      chk($sformatf("v%0d mode_changed", i), {1'b0, mode_changed}, {1'b0, vecs[i].mc});
    end
    rst = 1'b0; frame_end = 1'b0;

    // press latency measured cycle by cycle from the first low sample
    button = 1'b1;
    repeat (6) tick();
    button = 1'b0;
    lat = 0;
    while (req_mode == 2'b10 && lat < 20) begin
      tick();
      lat++;
    end
    chk("press latency", lat[1:0] == 2'(6) && lat == 6 ? 2'b01 : 2'b00, 2'b01);
    chk("latency req_mode", req_mode, 2'b01);
    chk("latency S held", S, 2'b00);

    // mode_changed is exactly one cycle wide, S stays put afterwards
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    mc_cnt = int'(mode_changed);
    for (int i = 0; i < 5; i++) begin
      tick();
      mc_cnt += int'(mode_changed);
      chk($sformatf("S stable %0d", i), S, 2'b01);
    end
    chk("mode_changed width", mc_cnt[1:0], 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_mode_ctrl.md
VGA_MODE_CTRL -- requirements
Module: vga_mode_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 500000, SHALL set the consecutive stable synchronized-button cycles required to accept a level change (legal range 2..2^20).
REQ-002 clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 button  input  1  raw push-button, active-low (0 = pressed), asynchronous to clk, bouncing.
REQ-005 frame_end  input  1  one-cycle pulse from VGA timing at the last active pixel of each frame.
REQ-006 S  output  2  display mode currently applied to the VGA datapath.
REQ-007 req_mode  output  2  mode requested by the user, not yet necessarily applied.
REQ-008 pending  output  1  high while req_mode != S.
REQ-009 mode_changed  output  1  one-cycle pulse signalling that S has just updated.

Function
REQ-010 button SHALL pass through a 2-flop synchronizer; only the second flop output (btn_s) SHALL feed downstream logic.
REQ-011 Debounce FSM states SHALL be STABLE_HI, WAIT_LO, STABLE_LO, WAIT_HI, with a cycle counter cnt wide enough for DB_CYCLES.
REQ-012 STABLE_HI: btn_s=0 -> WAIT_LO with cnt=1; else stay.
REQ-013 WAIT_LO: btn_s=1 -> STABLE_HI with cnt=0; btn_s=0 and cnt=DB_CYCLES-1 -> STABLE_LO with cnt=0 (accepted press); else cnt+1.
REQ-014 STABLE_LO: btn_s=1 -> WAIT_HI with cnt=1; else stay.
REQ-015 WAIT_HI: btn_s=0 -> STABLE_LO with cnt=0; btn_s=1 and cnt=DB_CYCLES-1 -> STABLE_HI with cnt=0 (release); else cnt+1.
REQ-016 An accepted press SHALL be the WAIT_LO->STABLE_LO transition only; releases and aborted waits SHALL produce no action.
REQ-017 On the clock edge of an accepted press, req_mode SHALL advance one step in the fixed cycle 00->10->01->11->00.
REQ-018 Holding the button SHALL produce exactly one advance, regardless of hold duration.
REQ-019 Each accepted press SHALL advance req_mode, even if earlier advances are not yet applied; four presses within one frame SHALL return req_mode to S.
REQ-020 pending SHALL be combinational: (req_mode != S).
REQ-021 On a cycle with frame_end=1 and pending=1, S SHALL load req_mode at that edge, and mode_changed SHALL be 1 in the following cycle only.
REQ-022 frame_end with pending=0 SHALL leave S unchanged and SHALL NOT pulse mode_changed.
REQ-023 S SHALL change only at frame_end edges; mid-frame mode change is forbidden.
REQ-024 When press and frame_end coincide, S SHALL take the pre-press req_mode, and req_mode SHALL advance at the same edge; pending stays 1 if the values differ.
REQ-025 Press-to-req_mode latency SHALL be DB_CYCLES+2 cycles from the first clean low sample of button, with no bounce.
REQ-026 All outputs SHALL be glitch-free registers, except pending.

Reset
REQ-027 While rst=1 at a clock edge: S=00, req_mode=00, mode_changed=0, FSM=STABLE_HI, cnt=0, synchronizer flops=1.
REQ-028 Reset mid-debounce or with a change pending SHALL discard all in-flight state; no advance SHALL be produced from pre-reset activity.
REQ-029 Button held low through reset release SHALL be treated as a new press once DB_CYCLES stable low cycles elapse after release.

Verification (bench DB_CYCLES=4)
REQ-030 Clean press: button low from cycle 10, frame_end at cycle 40 -> req_mode=10 at cycle 16, pending=1 during 16..40, S=10 after edge 40, mode_changed=1 in cycle 41 only.
REQ-031 Bounce: button toggles low/high every 2 cycles for 12 cycles, then holds low -> exactly one advance (00->10), occurring 6 cycles after the final low edge.
REQ-032 Multi-press: three clean presses with no frame_end, then frame_end -> req_mode goes 10, 01, 11; S jumps 00->11 in one step; one mode_changed pulse.
REQ-033 Coincidence: press accepted on the same edge as frame_end with S=00, req_mode=10 -> S=10, req_mode=01, pending=1.
REQ-034 Reset mid-WAIT_LO (cnt=2): rst for 1 cycle, button released -> S=00, req_mode=00, no advance, no mode_changed.
REQ-035 Full wrap: four applied presses, each followed by frame_end -> S sequence 10, 01, 11, 00; four mode_changed pulses.
